// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game datapath.
//   X_W, Y_W      : default coordinate widths for the X and Y axes
//   MAX_LEN       : number of segment registers per axis
//   LEN_W         : width of the length / index buses (2**LEN_W > MAX_LEN)
//   XSCREEN/YSCREEN/SEG_SIZE : screen geometry used by the drawing logic
//   seg_op_e      : per-step operation applied to every segment register
package snake_pkg;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned MAX_LEN  = 16;
    localparam int unsigned LEN_W    = 5;
    localparam int unsigned XSCREEN  = 160;
    localparam int unsigned YSCREEN  = 120;
    localparam int unsigned SEG_SIZE = 10;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_SHIFT = 2'd1,
        OP_LOAD  = 2'd2
    } seg_op_e;

endpackage

// File: rtl/snake_segment_reg.sv
// One coordinate of one snake segment.
// Ports:
//   CLOCK_50     : system clock, rising edge
//   Resetn       : synchronous active-low reset, clears the register
//   load_i       : take load_data_i (wins over shift_i)
//   load_data_i  : parallel-load value
//   shift_i      : take shift_data_i (predecessor segment or new head)
//   shift_data_i : shift value
//   active_i     : segment lies inside the effective length; an inactive
//                  segment clears to 0 on any load or shift
//   q_o          : stored coordinate
module snake_segment_reg #(
    parameter int unsigned N = 8
) (
    input  logic         CLOCK_50,
    input  logic         Resetn,
    input  logic         load_i,
    input  logic [N-1:0] load_data_i,
    input  logic         shift_i,
    input  logic [N-1:0] shift_data_i,
    input  logic         active_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = active_i ? load_data_i : '0;
        end else if (shift_i) begin
            q_d = active_i ? shift_data_i : '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/shift_register_move_snake.sv
// Coordinate shift register for one axis of every snake segment.
// Each shift moves head_in into segment 0 and every active segment takes
// its predecessor's value; segments at or beyond the effective length
// clear to 0 on every load or shift.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   Resetn   : synchronous active-low reset
//   length   : requested number of segments (0 -> 1, >MAX_LEN -> MAX_LEN)
//   body_in  : parallel load image, segment i at [i*N +: N]
//   head_in  : new head coordinate
//   body_out : segment register image, same packing as body_in
//   shift    : advance the body one step
//   load     : parallel load from body_in (wins over shift)
//   rd_idx   : read port segment index
//   rd_coord : combinational read of segment rd_idx (0 if outside length)
// Build option: define SNAKE_READ_PORT_EN to compile in the read port;
// otherwise rd_coord is tied to 0 and rd_idx is ignored.
module shift_register_move_snake
    import snake_pkg::*;
#(
    parameter int unsigned N       = snake_pkg::X_W,
    parameter int unsigned MAX_LEN = snake_pkg::MAX_LEN,
    parameter int unsigned LEN_W   = snake_pkg::LEN_W
) (
    input  logic                 CLOCK_50,
    input  logic                 Resetn,
    input  logic [LEN_W-1:0]     length,
    input  logic [N*MAX_LEN-1:0] body_in,
    input  logic [N-1:0]         head_in,
    output logic [N*MAX_LEN-1:0] body_out,
    input  logic                 shift,
    input  logic                 load,
    input  logic [LEN_W-1:0]     rd_idx,
    output logic [N-1:0]         rd_coord
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] active;
    logic [N-1:0]       seg [MAX_LEN];
    seg_op_e            op;

    always_comb begin
        len_eff = length;
        if (length == '0) begin
            len_eff = LEN_ONE;
        end else if (length > LEN_MAX) begin
            len_eff = LEN_MAX;
        end
    end

    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (shift) begin
            op = OP_SHIFT;
        end
    end

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
        logic [N-1:0] shift_src;

        if (i == 0) begin : g_head
            assign shift_src = head_in;
        end else begin : g_body
            assign shift_src = seg[i-1];
        end

        assign active[i] = (LEN_W'(i) < len_eff);

        snake_segment_reg #(
            .N (N)
        ) u_seg (
            .CLOCK_50     (CLOCK_50),
            .Resetn       (Resetn),
            .load_i       (op == OP_LOAD),
            .load_data_i  (body_in[i*N +: N]),
            .shift_i      (op == OP_SHIFT),
            .shift_data_i (shift_src),
            .active_i     (active[i]),
            .q_o          (seg[i])
        );

        assign body_out[i*N +: N] = seg[i];
    end

`ifdef SNAKE_READ_PORT_EN
    // Gate on the current effective length, not only on stored zeros: a
    // length change takes effect combinationally here before the next step.
    always_comb begin
        rd_coord = '0;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if ((LEN_W'(k) == rd_idx) && (rd_idx < len_eff)) begin
                rd_coord = seg[k];
            end
        end
    end
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_coord      = '0;
`endif

endmodule

// File: tb/tb_shift_register_move_snake.sv
module tb_shift_register_move_snake;

    localparam int NW   = 8;
    localparam int ML   = 16;
    localparam int LW   = 5;
    localparam int BW   = NW * ML;

    logic            clk = 1'b0;
    logic            Resetn;
    logic [LW-1:0]   length;
    logic [BW-1:0]   body_in;
    logic [NW-1:0]   head_in;
    logic [BW-1:0]   body_out;
    logic            shift;
    logic            load;
    logic [LW-1:0]   rd_idx;
    logic [NW-1:0]   rd_coord;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    int unsigned m_seg [ML];

    always #5 clk = ~clk;

    shift_register_move_snake #(
        .N       (NW),
        .MAX_LEN (ML),
        .LEN_W   (LW)
    ) dut (
        .CLOCK_50 (clk),
        .Resetn   (Resetn),
        .length   (length),
        .body_in  (body_in),
        .head_in  (head_in),
        .body_out (body_out),
        .shift    (shift),
        .load     (load),
        .rd_idx   (rd_idx),
        .rd_coord (rd_coord)
    );

    function automatic int unsigned eff_len(input int unsigned len);
        if (len == 0) return 1;
        if (len > ML) return ML;
        return len;
    endfunction

    function automatic logic [BW-1:0] model_image();
        logic [BW-1:0] img;
        img = '0;
        for (int i = 0; i < ML; i++) img[i*NW +: NW] = NW'(m_seg[i]);
        return img;
    endfunction

    function automatic logic [NW-1:0] model_rd();
`ifdef SNAKE_READ_PORT_EN
        if (int'(rd_idx) < int'(eff_len(length))) return NW'(m_seg[rd_idx]);
`endif
        return '0;
    endfunction

    // Reference behaviour: the body is a list of coordinates, head first,
    // truncated to the effective length and padded with zeros.
    task automatic model_apply();
        int unsigned nxt[$];
        int unsigned L;
        L = eff_len(length);
        if (!Resetn) begin
            for (int i = 0; i < ML; i++) m_seg[i] = 0;
        end else if (load) begin
            for (int i = 0; i < ML; i++) m_seg[i] = (i < L) ? int'(body_in[i*NW +: NW]) : 0;
        end else if (shift) begin
            nxt.push_back(int'(head_in));
            for (int i = 0; i < int'(L) - 1; i++) nxt.push_back(m_seg[i]);
            for (int i = 0; i < ML; i++) m_seg[i] = (i < nxt.size()) ? nxt[i] : 0;
        end
    endtask

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs compared on
    // the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_apply();
        #2;
    endtask

    function automatic logic [NW-1:0] seg_of(input int i);
        return body_out[i*NW +: NW];
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("body_out", body_out, model_image());
            chk("rd_coord", BW'(rd_coord), BW'(model_rd()));
        end
    end

    initial begin
        logic [BW-1:0] img;
        logic [NW-1:0] exp_rd;

        Resetn  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        length  = 5'd2;
        body_in = '0;
        head_in = '0;
        rd_idx  = '0;
        for (int i = 0; i < ML; i++) m_seg[i] = 0;
        cycle();
        check_en = 1'b1;
        chk("reset_body", body_out, '0);
        chk("reset_rd", BW'(rd_coord), '0);
        Resetn = 1'b1;

        // Load length 2: seg0=39, seg1=29, upper segments offered 55
        for (int i = 0; i < ML; i++) body_in[i*NW +: NW] = 8'd55;
        body_in[7:0]  = 8'd39;
        body_in[15:8] = 8'd29;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("load_seg0", BW'(seg_of(0)), BW'(39));
        chk("load_seg1", BW'(seg_of(1)), BW'(29));
        chk("load_upper", body_out >> 16, '0);

        head_in = 8'd40; shift = 1'b1;
        cycle();
        chk("shift1", BW'({seg_of(1), seg_of(0)}), BW'({8'd39, 8'd40}));
        head_in = 8'd41;
        cycle();
        shift = 1'b0;
        chk("shift2", BW'({seg_of(1), seg_of(0)}), BW'({8'd40, 8'd41}));

        rd_idx = 5'd1; #1;
`ifdef SNAKE_READ_PORT_EN
        exp_rd = 8'd40;
`else
        exp_rd = 8'd0;
`endif
        chk("rd_idx1", BW'(rd_coord), BW'(exp_rd));

        // Grow to 3: new tail duplicates old tail
        length = 5'd3; head_in = 8'd42; shift = 1'b1;
        cycle();
        shift = 1'b0;
        chk("grow", BW'(body_out), BW'({8'd40, 8'd41, 8'd42}));
        rd_idx = 5'd5; #1;
        chk("rd_outside_len", BW'(rd_coord), '0);

        // Shrink to 1
        length = 5'd1; head_in = 8'd43; shift = 1'b1;
        cycle();
        shift = 1'b0;
        chk("shrink", body_out, BW'(43));

        // Load and shift together: load wins
        length = 5'd4; body_in = {$urandom, $urandom, $urandom, $urandom};
        head_in = 8'd99; load = 1'b1; shift = 1'b1;
        img = '0;
        img[31:0] = body_in[31:0];
        cycle();
        load = 1'b0; shift = 1'b0;
        chk("load_over_shift", body_out, img);

        // length 0 acts as 1
        length = 5'd0; head_in = 8'd7; shift = 1'b1;
        cycle();
        shift = 1'b0;
        chk("len0_clamp", body_out, BW'(7));

        // length 31 acts as MAX_LEN
        length = 5'd31;
        for (int i = 0; i < ML; i++) body_in[i*NW +: NW] = NW'(i + 100);
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("len31_clamp", body_out, body_in);

        // Reset wins over load
        Resetn = 1'b0; load = 1'b1;
        cycle();
        Resetn = 1'b1; load = 1'b0;
        chk("reset_mid", body_out, '0);

        // Random traffic; the negedge process compares every cycle
        for (int c = 0; c < 3000; c++) begin
            Resetn  = ($urandom_range(0, 63) != 0);
            load    = ($urandom_range(0, 7) == 0);
            shift   = ($urandom_range(0, 2) == 0);
            length  = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 31))
                                                  : LW'($urandom_range(0, 17));
            body_in = {$urandom, $urandom, $urandom, $urandom};
            head_in = NW'($urandom);
            rd_idx  = LW'($urandom_range(0, 31));
            cycle();
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
